acog_seq_hub: RTL and testbench
===============================

Name: acog_seq_hub

Overview:
- Parametrised next-generation cog sequencer.
- Steps each instruction through FETCH/DECODE/READ/WBACK.
- Stalls in READ for hub transfers and for WAITCNT/WAITPEQ/WAITPNE/WAITVID.
- New over the previous sequencer:
  - Hub requests launch only in this cog's round-robin hub slot.
  - Hub requests time out.
  - Stall cycles are counted.
- Sits between the cog decoder/ALU and the hub arbiter.

Parameters:
- NUM_COGS, 8: cogs sharing the hub; slot counter modulus, power of two, 2..16.
- COG_ID, 0: this cog's hub slot, 0..NUM_COGS-1.
- HUB_TIMEOUT, 32: request-asserted cycles before abort, 2..255.
- STALL_W, 16: width of the stall counter.

Ports:
- clk_in  in  1  clock; all state changes on the rising edge.
- reset_in  in  1  reset, synchronous, active-high.
- state_o  out  2  current state: FETCH=0, DECODE=1, READ=2, WBACK=3.
- opcode_in  in  32  current instruction; [31:26] opcode, [23] R bit; stable from DECODE through WBACK.
- execute_in  in  1  condition-code pass for the current instruction.
- flag_c_in  in  1  C flag; selects pin port B (1) or A (0) for WAITPEQ/WAITPNE.
- port_peq_pina_in, port_peq_pinb_in  in  1 each  pin-equal match, port A / B.
- port_pne_pina_in, port_pne_pinb_in  in  1 each  pin-not-equal match, port A / B.
- port_cnt_eq_d_in  in  1  CNT equals D.
- port_vid_rdy_in  in  1  video generator ready to accept data.
- hub_ack_in  in  1  hub transfer complete, one-cycle pulse.
- hub_read_o  out  1  hub read request.
- hub_write_o  out  1  hub write request.
- hub_tfr_sz_o  out  2  transfer size: BYTE=0, WORD=1, LONG=2.
- hub_slot_o  out  clog2(NUM_COGS)  current round-robin hub slot.
- hub_err_o  out  1  one-cycle pulse on hub timeout.
- stall_cnt_o  out  STALL_W  total READ stall cycles; saturating.

Behaviour:
- Reset values: state_o=FETCH, all hub outputs 0, hub_slot_o=0, hub_err_o=0, stall_cnt_o=0, internal settle flag 0, timeout counter 0.
- Reset mid-transfer drops any request in the same edge; a late hub_ack_in after reset is ignored.
- Hub slot: increments by 1 every cycle modulo NUM_COGS, independent of state.
- FETCH -> DECODE -> READ unconditionally, one cycle each; FETCH clears the settle flag.
- READ with execute_in=0: -> WBACK next cycle, no request, no stall count.
- READ with execute_in=1, first cycle is the settle cycle:
  - Sets the settle flag.
  - Stalling opcodes (RDBYTE/RDWORD/RDLONG, WAITCNT/WAITPEQ/WAITPNE/WAITVID) stay in READ.
  - All other opcodes -> WBACK.
- Hub ops, evaluated once settled:
  - No request active and hub_slot_o==COG_ID: assert hub_read_o if R=1, else hub_write_o; drive hub_tfr_sz_o from the opcode.
  - Request active and hub_ack_in=1: deassert the request and go to WBACK in the same edge.
  - hub_ack_in while no request is active is ignored.
- Timeout:
  - Counts cycles with a request asserted.
  - At HUB_TIMEOUT with no ack: deassert the request, pulse hub_err_o, go to WBACK.
  - An ack on the timeout cycle wins; no error is flagged.
- Waits, evaluated once settled:
  - WAITCNT advances on port_cnt_eq_d_in.
  - WAITPEQ/WAITPNE advance on the B-port match when C=1, on the A-port match when C=0.
  - WAITVID advances on port_vid_rdy_in.
  - A condition already true on the settle cycle advances on the following cycle.
- Stall counter: +1 for every READ cycle that does not transition out; saturates at all-ones.
- WBACK -> FETCH.
- The state register wraps 3 -> 0 via 2-bit increment.
- Only one of hub_read_o/hub_write_o is ever high.

Decomposition:
- Package acog_defs:
  - State encodings ST_FETCH/ST_DECODE/ST_READ/ST_WBACK.
  - Opcodes: I_RDBYTE=6'h00, I_RDWORD=6'h01, I_RDLONG=6'h02, I_WAITPEQ=6'h3C, I_WAITPNE=6'h3D, I_WAITCNT=6'h3E, I_WAITVID=6'h3F.
  - OP_R=23.
  - SZ_BYTE/SZ_WORD/SZ_LONG.
- One sub-module, acog_hub_req: slot counter, request/ack/timeout logic, err pulse.
- Main module keeps the state machine, wait-condition mux and stall counter.

Test Plan:
- NOP (opcode 6'h10), execute_in=1 -> state_o sequence 0,1,2,3,0 with no stall; stall_cnt_o stays 0.
- RDLONG, R=1, COG_ID=3, slot 0 entering READ -> hub_read_o rises at the edge where slot==3 with hub_tfr_sz_o=2; ack 4 cycles later -> request drops, state 3 next cycle.
- WRBYTE (RDBYTE, R=0), no ack, HUB_TIMEOUT=32 -> hub_write_o high exactly 32 cycles, hub_err_o single pulse, then WBACK.
- WAITPEQ, C=1, pinb match after 10 cycles while pina matches throughout -> advances only on the pinb match; stall_cnt_o increments by 10 plus the settle cycle.
- RDWORD with execute_in=0 -> READ lasts 1 cycle, no hub request, stall_cnt_o unchanged.
- reset_in asserted during an active hub_read_o -> next cycle all outputs 0, state_o=0; an ack one cycle later has no effect.

Source files
------------

// File: rtl/acog_seq_hub_pkg.sv
// ============================================================================
// Module  : acog_defs
// Brief   : State, opcode and transfer-size definitions for the cog sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package acog_defs;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_READ   = 2'd2,
        ST_WBACK  = 2'd3
    } state_t;

    localparam logic [5:0] I_RDBYTE  = 6'h00;
    localparam logic [5:0] I_RDWORD  = 6'h01;
    localparam logic [5:0] I_RDLONG  = 6'h02;
    localparam logic [5:0] I_WAITPEQ = 6'h3C;
    localparam logic [5:0] I_WAITPNE = 6'h3D;
    localparam logic [5:0] I_WAITCNT = 6'h3E;
    localparam logic [5:0] I_WAITVID = 6'h3F;

    localparam int OP_R = 23;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_LONG = 2'd2;

    function automatic logic [1:0] hub_size(input logic [5:0] op);
        case (op)
            I_RDWORD: hub_size = SZ_WORD;
            I_RDLONG: hub_size = SZ_LONG;
            default:  hub_size = SZ_BYTE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/acog_hub_req.sv
// ============================================================================
// Module  : acog_hub_req
// Brief   : Round-robin hub slot counter, request launch, ack and timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module acog_hub_req
    import acog_defs::*;
#(
    parameter int NUM_COGS    = 8,
    parameter int COG_ID      = 0,
    parameter int HUB_TIMEOUT = 32,
    localparam int SLOT_W     = $clog2(NUM_COGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_launch_en,
    input  logic              i_rd,
    input  logic [1:0]        i_sz,
    input  logic              i_ack,
    output logic              o_read,
    output logic              o_write,
    output logic [1:0]        o_sz,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_err,
    output logic              o_done
);

    localparam logic [SLOT_W-1:0] c_cog_slot = SLOT_W'(COG_ID);
    localparam logic [7:0]        c_tmo_last = 8'(HUB_TIMEOUT - 1);

    logic              r_read;
    logic              r_write;
    logic [1:0]        r_sz;
    logic [SLOT_W-1:0] r_slot;
    logic              r_err;
    logic [7:0]        r_tmo;

    logic w_active;
    logic w_tmo_hit;
    logic w_launch;

    assign w_active  = r_read | r_write;
    // An ack arriving on the final allowed cycle takes priority over the abort.
    assign w_tmo_hit = w_active && !i_ack && (r_tmo == c_tmo_last);
    assign o_done    = w_active && (i_ack || w_tmo_hit);
    assign w_launch  = i_launch_en && !w_active && (r_slot == c_cog_slot);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_sz    <= SZ_BYTE;
            r_slot  <= '0;
            r_err   <= 1'b0;
            r_tmo   <= 8'd0;
        end else begin
            r_slot <= r_slot + 1'b1;
            r_err  <= w_tmo_hit;
            if (o_done) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
                r_sz    <= SZ_BYTE;
                r_tmo   <= 8'd0;
            end else if (w_launch) begin
                r_read  <= i_rd;
                r_write <= !i_rd;
                r_sz    <= i_sz;
                r_tmo   <= 8'd0;
            end else if (w_active) begin
                r_tmo <= r_tmo + 8'd1;
            end
        end
    end

    assign o_read  = r_read;
    assign o_write = r_write;
    assign o_sz    = r_sz;
    assign o_slot  = r_slot;
    assign o_err   = r_err;

endmodule

`default_nettype wire

// File: rtl/acog_seq_hub.sv
// ============================================================================
// Module  : acog_seq_hub
// Brief   : Cog sequencer FETCH/DECODE/READ/WBACK with slotted hub access,
//           wait-condition stalls and a saturating stall counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module acog_seq_hub
    import acog_defs::*;
#(
    parameter int NUM_COGS    = 8,
    parameter int COG_ID      = 0,
    parameter int HUB_TIMEOUT = 32,
    parameter int STALL_W     = 16,
    localparam int SLOT_W     = $clog2(NUM_COGS)
) (
    input  logic               clk_in,
    input  logic               reset_in,
    output logic [1:0]         state_o,
    input  logic [31:0]        opcode_in,
    input  logic               execute_in,
    input  logic               flag_c_in,
    input  logic               port_peq_pina_in,
    input  logic               port_peq_pinb_in,
    input  logic               port_pne_pina_in,
    input  logic               port_pne_pinb_in,
    input  logic               port_cnt_eq_d_in,
    input  logic               port_vid_rdy_in,
    input  logic               hub_ack_in,
    output logic               hub_read_o,
    output logic               hub_write_o,
    output logic [1:0]         hub_tfr_sz_o,
    output logic [SLOT_W-1:0]  hub_slot_o,
    output logic               hub_err_o,
    output logic [STALL_W-1:0] stall_cnt_o
);

    state_t             r_state;
    state_t             w_next;
    logic               r_settled;
    logic [STALL_W-1:0] r_stall;

    logic [5:0] w_op;
    logic       w_is_hub;
    logic       w_is_wait;
    logic       w_wait_ok;
    logic       w_hub_done;
    logic       w_launch_en;
    logic       w_adv;
    logic       w_unused_opbits;

    assign w_op            = opcode_in[31:26];
    assign w_unused_opbits = ^{opcode_in[25:24], opcode_in[22:0]};
    assign w_is_hub        = (w_op == I_RDBYTE) || (w_op == I_RDWORD) || (w_op == I_RDLONG);
    assign w_is_wait       = (w_op == I_WAITPEQ) || (w_op == I_WAITPNE) ||
                             (w_op == I_WAITCNT) || (w_op == I_WAITVID);
    assign w_launch_en     = (r_state == ST_READ) && execute_in && r_settled && w_is_hub;

    always_comb begin
        w_wait_ok = 1'b0;
        case (w_op)
            I_WAITCNT: w_wait_ok = port_cnt_eq_d_in;
            I_WAITPEQ: w_wait_ok = flag_c_in ? port_peq_pinb_in : port_peq_pina_in;
            I_WAITPNE: w_wait_ok = flag_c_in ? port_pne_pinb_in : port_pne_pina_in;
            I_WAITVID: w_wait_ok = port_vid_rdy_in;
            default:   w_wait_ok = 1'b0;
        endcase
    end

    acog_hub_req #(
        .NUM_COGS    (NUM_COGS),
        .COG_ID      (COG_ID),
        .HUB_TIMEOUT (HUB_TIMEOUT)
    ) u_hub_req (
        .clk         (clk_in),
        .rst         (reset_in),
        .i_launch_en (w_launch_en),
        .i_rd        (opcode_in[OP_R]),
        .i_sz        (hub_size(w_op)),
        .i_ack       (hub_ack_in),
        .o_read      (hub_read_o),
        .o_write     (hub_write_o),
        .o_sz        (hub_tfr_sz_o),
        .o_slot      (hub_slot_o),
        .o_err       (hub_err_o),
        .o_done      (w_hub_done)
    );

    // The first executed READ cycle only settles; stalling ops never leave on it.
    always_comb begin
        w_adv = 1'b1;
        if (r_state == ST_READ) begin
            if (!execute_in) begin
                w_adv = 1'b1;
            end else if (!r_settled) begin
                w_adv = !(w_is_hub || w_is_wait);
            end else if (w_is_hub) begin
                w_adv = w_hub_done;
            end else if (w_is_wait) begin
                w_adv = w_wait_ok;
            end else begin
                w_adv = 1'b1;
            end
        end
        w_next = w_adv ? state_t'(r_state + 2'd1) : r_state;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state   <= ST_FETCH;
            r_settled <= 1'b0;
            r_stall   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_FETCH) begin
                r_settled <= 1'b0;
            end else if ((r_state == ST_READ) && execute_in) begin
                r_settled <= 1'b1;
            end
            if ((r_state == ST_READ) && !w_adv && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign state_o     = r_state;
    assign stall_cnt_o = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_acog_seq_hub.sv
// ============================================================================
// Module  : tb_acog_seq_hub
// Brief   : Directed cycle-by-cycle bench for acog_seq_hub (COG_ID=3).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acog_seq_hub;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [1:0]  state_o;
    logic [31:0] opcode_in;
    logic        execute_in;
    logic        flag_c_in;
    logic        port_peq_pina_in;
    logic        port_peq_pinb_in;
    logic        port_pne_pina_in;
    logic        port_pne_pinb_in;
    logic        port_cnt_eq_d_in;
    logic        port_vid_rdy_in;
    logic        hub_ack_in;
    logic        hub_read_o;
    logic        hub_write_o;
    logic [1:0]  hub_tfr_sz_o;
    logic [2:0]  hub_slot_o;
    logic        hub_err_o;
    logic [15:0] stall_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] c_op_nop    = 32'h4000_0000;
    localparam logic [31:0] c_op_waitcnt = 32'hF800_0000;
    localparam logic [31:0] c_op_waitpeq = 32'hF000_0000;
    localparam logic [31:0] c_op_rdlong = 32'h0880_0000;
    localparam logic [31:0] c_op_wrbyte = 32'h0000_0000;
    localparam logic [31:0] c_op_rdword = 32'h0480_0000;

    acog_seq_hub #(
        .NUM_COGS    (8),
        .COG_ID      (3),
        .HUB_TIMEOUT (32),
        .STALL_W     (16)
    ) dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .state_o          (state_o),
        .opcode_in        (opcode_in),
        .execute_in       (execute_in),
        .flag_c_in        (flag_c_in),
        .port_peq_pina_in (port_peq_pina_in),
        .port_peq_pinb_in (port_peq_pinb_in),
        .port_pne_pina_in (port_pne_pina_in),
        .port_pne_pinb_in (port_pne_pinb_in),
        .port_cnt_eq_d_in (port_cnt_eq_d_in),
        .port_vid_rdy_in  (port_vid_rdy_in),
        .hub_ack_in       (hub_ack_in),
        .hub_read_o       (hub_read_o),
        .hub_write_o      (hub_write_o),
        .hub_tfr_sz_o     (hub_tfr_sz_o),
        .hub_slot_o       (hub_slot_o),
        .hub_err_o        (hub_err_o),
        .stall_cnt_o      (stall_cnt_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic check_idle_hub(input string tag);
        check_vec({tag, "_rd"},  32'(hub_read_o),  32'd0);
        check_vec({tag, "_wr"},  32'(hub_write_o), 32'd0);
        check_vec({tag, "_err"}, 32'(hub_err_o),   32'd0);
    endtask

    initial begin
        int wcnt;
        int hi;
        logic err_seen;
        logic rd_seen;

        reset_in         = 1'b1;
        opcode_in        = c_op_nop;
        execute_in       = 1'b1;
        flag_c_in        = 1'b0;
        port_peq_pina_in = 1'b0;
        port_peq_pinb_in = 1'b0;
        port_pne_pina_in = 1'b0;
        port_pne_pinb_in = 1'b0;
        port_cnt_eq_d_in = 1'b0;
        port_vid_rdy_in  = 1'b0;
        hub_ack_in       = 1'b0;

        // Reset values
        repeat (3) step();
        check_vec("rst_state", 32'(state_o),      32'd0);
        check_idle_hub("rst");
        check_vec("rst_sz",    32'(hub_tfr_sz_o), 32'd0);
        check_vec("rst_slot",  32'(hub_slot_o),   32'd0);
        check_vec("rst_stall", 32'(stall_cnt_o),  32'd0);
        reset_in = 1'b0;

        step();
        check_vec("post_rst_state", 32'(state_o),    32'd1);
        check_vec("post_rst_slot",  32'(hub_slot_o), 32'd1);
        repeat (3) step();

        // NOP: one cycle per state, no stalls (FETCH at slot 4)
        check_vec("nop_f",  32'(state_o), 32'd0);
        check_vec("nop_fs", 32'(hub_slot_o), 32'd4);
        step(); check_vec("nop_d", 32'(state_o), 32'd1);
        step(); check_vec("nop_r", 32'(state_o), 32'd2);
        step(); check_vec("nop_w", 32'(state_o), 32'd3);
        step(); check_vec("nop_f2", 32'(state_o), 32'd0);
        check_vec("nop_stall", 32'(stall_cnt_o), 32'd0);
        check_vec("nop_slot",  32'(hub_slot_o),  32'd0);

        // WAITCNT released in the slot-4 READ cycle so next FETCH sits at slot 6
        opcode_in = c_op_waitcnt;
        step(); step(); step();
        check_vec("wcnt_hold", 32'(state_o), 32'd2);
        step();
        port_cnt_eq_d_in = 1'b1;
        step();
        port_cnt_eq_d_in = 1'b0;
        check_vec("wcnt_w",     32'(state_o),     32'd3);
        check_vec("wcnt_stall", 32'(stall_cnt_o), 32'd2);
        step();
        check_vec("pad_f_slot", 32'(hub_slot_o), 32'd6);

        // RDLONG R=1: READ entered at slot 0, request rises after the slot-3 cycle
        opcode_in = c_op_rdlong;
        step(); step();
        check_vec("rdl_slot0", 32'(hub_slot_o), 32'd0);
        check_vec("rdl_settle_rd", 32'(hub_read_o), 32'd0);
        step(); step(); step();
        check_vec("rdl_slot3_state", 32'(state_o),    32'd2);
        check_vec("rdl_slot3_rd",    32'(hub_read_o), 32'd0);
        step();
        check_vec("rdl_rise_rd", 32'(hub_read_o),   32'd1);
        check_vec("rdl_rise_wr", 32'(hub_write_o),  32'd0);
        check_vec("rdl_rise_sz", 32'(hub_tfr_sz_o), 32'd2);
        step(); step(); step();
        check_vec("rdl_hold_rd", 32'(hub_read_o), 32'd1);
        hub_ack_in = 1'b1;
        step();
        hub_ack_in = 1'b0;
        check_vec("rdl_ack_state", 32'(state_o), 32'd3);
        check_idle_hub("rdl_ack");
        check_vec("rdl_stall", 32'(stall_cnt_o), 32'd9);
        step();

        // WRBYTE with no ack: 32-cycle request then a single error pulse
        opcode_in = c_op_wrbyte;
        step(); step();
        wcnt = 0;
        while (!hub_write_o && wcnt < 20) begin
            step();
            wcnt++;
        end
        check_vec("wrb_launch_delay", 32'(wcnt), 32'd9);
        check_vec("wrb_sz", 32'(hub_tfr_sz_o), 32'd0);
        hi = 0;
        err_seen = 1'b0;
        rd_seen = 1'b0;
        while (hub_write_o && hi < 100) begin
            if (hub_err_o) err_seen = 1'b1;
            if (hub_read_o) rd_seen = 1'b1;
            step();
            hi++;
        end
        check_vec("wrb_high_cycles", 32'(hi), 32'd32);
        check_vec("wrb_early_err", 32'(err_seen), 32'd0);
        check_vec("wrb_rd_excl",   32'(rd_seen),  32'd0);
        check_vec("wrb_err_pulse", 32'(hub_err_o), 32'd1);
        check_vec("wrb_tmo_state", 32'(state_o),   32'd3);
        step();
        check_vec("wrb_err_clear", 32'(hub_err_o),   32'd0);
        check_vec("wrb_f",         32'(state_o),     32'd0);
        check_vec("wrb_stall",     32'(stall_cnt_o), 32'd49);

        // WAITPEQ C=1: pin A matching throughout must not release it
        opcode_in        = c_op_waitpeq;
        flag_c_in        = 1'b1;
        port_peq_pina_in = 1'b1;
        step(); step();
        check_vec("peq_settle", 32'(state_o), 32'd2);
        repeat (10) step();
        check_vec("peq_hold", 32'(state_o), 32'd2);
        step();
        port_peq_pinb_in = 1'b1;
        step();
        port_peq_pinb_in = 1'b0;
        port_peq_pina_in = 1'b0;
        flag_c_in        = 1'b0;
        check_vec("peq_w",     32'(state_o),     32'd3);
        check_vec("peq_stall", 32'(stall_cnt_o), 32'd60);
        step();

        // RDWORD not executed: single READ cycle, no request, no stall
        opcode_in  = c_op_rdword;
        execute_in = 1'b0;
        step(); step();
        check_vec("rdw_r", 32'(state_o), 32'd2);
        check_idle_hub("rdw_r");
        step();
        check_vec("rdw_w", 32'(state_o), 32'd3);
        check_idle_hub("rdw_w");
        check_vec("rdw_stall", 32'(stall_cnt_o), 32'd60);
        step();
        execute_in = 1'b1;

        // Reset while a read request is active; a later ack is ignored
        opcode_in = c_op_rdlong;
        repeat (4) step();
        check_vec("rst6_rd_active", 32'(hub_read_o), 32'd1);
        reset_in = 1'b1;
        step();
        check_vec("rst6_state", 32'(state_o),      32'd0);
        check_idle_hub("rst6");
        check_vec("rst6_sz",    32'(hub_tfr_sz_o), 32'd0);
        check_vec("rst6_slot",  32'(hub_slot_o),   32'd0);
        check_vec("rst6_stall", 32'(stall_cnt_o),  32'd0);
        reset_in   = 1'b0;
        hub_ack_in = 1'b1;
        step();
        hub_ack_in = 1'b0;
        check_vec("late_ack_state", 32'(state_o),     32'd1);
        check_idle_hub("late_ack");
        check_vec("late_ack_stall", 32'(stall_cnt_o), 32'd0);
        check_vec("late_ack_slot",  32'(hub_slot_o),  32'd1);
        opcode_in = c_op_nop;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
